// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the decode/control pipeline:
//   - opcode constants for the non-ALU instructions
//   - bit positions inside the 11-bit control word
//     {BranchReg,Branch,FlagEn,RegDst,ALUSrc | MemEnable,MemWrite,MemRead | PCSave,MemtoReg,RegWrite}
//   - encoding of the halt-sequencing FSM states
package cpu_ctrl_pkg;

  localparam int CW_W = 11;
  typedef logic [CW_W-1:0] ctrl_word_t;

  // WB field
  localparam int CW_REGWRITE  = 0;
  localparam int CW_MEMTOREG  = 1;
  localparam int CW_PCSAVE    = 2;
  // MEM field
  localparam int CW_MEMREAD   = 3;
  localparam int CW_MEMWRITE  = 4;
  localparam int CW_MEMENABLE = 5;
  // EX field
  localparam int CW_ALUSRC    = 6;
  localparam int CW_REGDST    = 7;
  localparam int CW_FLAGEN    = 8;
  localparam int CW_BRANCH    = 9;
  localparam int CW_BRANCHREG = 10;

  // Field boundaries used when splitting the word across stages
  localparam int EX_LSB  = 6;
  localparam int MEM_LSB = 3;

  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_DRAIN  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational opcode -> control-word decoder.
// Ports:
//   opcode_i  [OPW-1:0]  opcode of the instruction in ID
//   ctrl_o    [10:0]     control word (layout in cpu_ctrl_pkg)
// Opcodes that do not fit in 4 bits decode to an all-zero word.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int          OPW       = 4,
  parameter logic [15:0] FLAG_MASK = 16'h0077
) (
  input  logic [OPW-1:0] opcode_i,
  output ctrl_word_t     ctrl_o
);

  logic       opHigh;
  logic [3:0] op4;

  // Shifting rather than slicing keeps this legal when OPW is exactly 4.
  assign opHigh = |(opcode_i >> 4);
  assign op4    = opcode_i[3:0];

  // Decode table; FlagEn comes from the per-opcode mask parameter.
  always_comb begin
    ctrl_o = '0;
    if (!opHigh) begin
      case (op4)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
          ctrl_o[CW_REGDST]   = 1'b1;
          ctrl_o[CW_REGWRITE] = 1'b1;
        end
        4'h4, 4'h5, 4'h6, 4'hA, 4'hB: begin
          ctrl_o[CW_REGDST]   = 1'b1;
          ctrl_o[CW_REGWRITE] = 1'b1;
          ctrl_o[CW_ALUSRC]   = 1'b1;
        end
        OP_LD: begin
          ctrl_o[CW_ALUSRC]    = 1'b1;
          ctrl_o[CW_MEMREAD]   = 1'b1;
          ctrl_o[CW_MEMTOREG]  = 1'b1;
          ctrl_o[CW_MEMENABLE] = 1'b1;
          ctrl_o[CW_REGWRITE]  = 1'b1;
          ctrl_o[CW_REGDST]    = 1'b1;
        end
        OP_ST: begin
          ctrl_o[CW_ALUSRC]    = 1'b1;
          ctrl_o[CW_MEMWRITE]  = 1'b1;
          ctrl_o[CW_MEMENABLE] = 1'b1;
        end
        OP_B:   ctrl_o[CW_BRANCH]    = 1'b1;
        OP_BR:  ctrl_o[CW_BRANCHREG] = 1'b1;
        OP_PCS: begin
          ctrl_o[CW_REGWRITE] = 1'b1;
          ctrl_o[CW_PCSAVE]   = 1'b1;
          ctrl_o[CW_REGDST]   = 1'b1;
        end
        OP_HLT:  ctrl_o[CW_REGDST] = 1'b1;
        default: ctrl_o = '0;
      endcase
      ctrl_o[CW_FLAGEN] = FLAG_MASK[op4];
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
// Decodes the ID instruction and carries its control bits down the
// ID/EX -> EX/MEM -> MEM/WB registers, and sequences HLT: once a HLT is
// accepted, fetch is held while the pipeline drains, then halted asserts.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   id_valid, id_opcode          instruction in ID
//   stall, flush                 hold ID / kill ID (both insert a bubble)
//   ex_ctrl[4:0]                 {BranchReg,Branch,FlagEn,RegDst,ALUSrc}
//   mem_ctrl[2:0]                {MemEnable,MemWrite,MemRead}
//   wb_ctrl[2:0]                 {PCSave,MemtoReg,RegWrite}
//   ex_valid, mem_valid, wb_valid  stage holds a real instruction
//   fetch_hold                   fetch must stop (draining or halted)
//   halted                       HLT has fully drained
module decode_ctrl_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int          OPW          = 4,
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [15:0] FLAG_MASK    = 16'h0077
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_opcode,
  input  logic           stall,
  input  logic           flush,
  output logic [4:0]     ex_ctrl,
  output logic [2:0]     mem_ctrl,
  output logic [2:0]     wb_ctrl,
  output logic           ex_valid,
  output logic           mem_valid,
  output logic           wb_valid,
  output logic           fetch_hold,
  output logic           halted
);

  localparam int              CNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  ctrl_word_t       decodeWord;
  logic             accept;
  logic             hltCapture;

  ctrl_word_t       idEx_q, idEx_d;
  logic             idExValid_q, idExValid_d;
  logic [5:0]       exMem_q;
  logic             exMemValid_q;
  logic [2:0]       memWb_q;
  logic             memWbValid_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_decode #(
    .OPW      (OPW),
    .FLAG_MASK(FLAG_MASK)
  ) u_decode (
    .opcode_i(id_opcode),
    .ctrl_o  (decodeWord)
  );

  // Only a clean, unstalled, unflushed instruction while running gets in;
  // everything else (including all of DRAIN/HALTED) becomes a bubble.
  assign accept     = id_valid && !stall && !flush && (state_q == ST_RUN);
  assign hltCapture = accept && (id_opcode == OPW'(OP_HLT));

  // ID/EX next value: the decoded word or an all-zero bubble.
  always_comb begin
    idEx_d      = accept ? decodeWord : '0;
    idExValid_d = accept;
  end

  // Halt sequencing. The counter is loaded with DRAIN_CYCLES-1 so that
  // HALTED is entered exactly DRAIN_CYCLES edges after the HLT capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (hltCapture) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Pipeline registers and FSM. Later stages shift every cycle regardless
  // of stall, so stalled instructions drain out ahead of the bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idEx_q       <= '0;
      idExValid_q  <= 1'b0;
      exMem_q      <= '0;
      exMemValid_q <= 1'b0;
      memWb_q      <= '0;
      memWbValid_q <= 1'b0;
      state_q      <= ST_RUN;
      cnt_q        <= '0;
    end else begin
      idEx_q       <= idEx_d;
      idExValid_q  <= idExValid_d;
      exMem_q      <= idEx_q[5:0];
      exMemValid_q <= idExValid_q;
      memWb_q      <= exMem_q[2:0];
      memWbValid_q <= exMemValid_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_ctrl    = idEx_q[CW_W-1:EX_LSB];
  assign mem_ctrl   = exMem_q[5:MEM_LSB];
  assign wb_ctrl    = memWb_q;
  assign ex_valid   = idExValid_q;
  assign mem_valid  = exMemValid_q;
  assign wb_valid   = memWbValid_q;
  assign fetch_hold = (state_q != ST_RUN);
  assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Testbench for decode_ctrl_pipe: table of single-cycle decode vectors,
// then directed multi-cycle sequences for stall/flush, HLT drain and reset.
// A second instance (OPW=5, DRAIN_CYCLES=1) covers the wide-opcode and
// one-cycle-drain boundaries.
module tb_decode_ctrl_pipe;

  typedef struct {
    logic       v;
    logic [3:0] op;
    logic       st;
    logic       fl;
    logic       ev;
    logic [4:0] ex;
    logic [2:0] mem;
    logic [2:0] wb;
  } vec_t;

  localparam int NVEC = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, stall, flush;
  logic [3:0] id_opcode;
  logic [4:0] ex_ctrl;
  logic [2:0] mem_ctrl, wb_ctrl;
  logic       ex_valid, mem_valid, wb_valid, fetch_hold, halted;

  logic       id_valid5, stall5, flush5;
  logic [4:0] id_opcode5;
  logic [4:0] ex_ctrl5;
  logic [2:0] mem_ctrl5, wb_ctrl5;
  logic       ex_valid5, mem_valid5, wb_valid5, fetch_hold5, halted5;

  int checkCount = 0;
  int passCount  = 0;

  vec_t vecs [NVEC];

  decode_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .stall(stall), .flush(flush), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .fetch_hold(fetch_hold), .halted(halted)
  );

  decode_ctrl_pipe #(.OPW(5), .DRAIN_CYCLES(1), .FLAG_MASK(16'h0077)) dut5 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid5), .id_opcode(id_opcode5),
    .stall(stall5), .flush(flush5), .ex_ctrl(ex_ctrl5), .mem_ctrl(mem_ctrl5),
    .wb_ctrl(wb_ctrl5), .ex_valid(ex_valid5), .mem_valid(mem_valid5),
    .wb_valid(wb_valid5), .fetch_hold(fetch_hold5), .halted(halted5)
  );

  // Compare one value and keep the tallies.
  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Drive the default instance's inputs, advance one edge, settle.
  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic st, input logic fl);
    id_valid  = v;
    id_opcode = op;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ex_ctrl"},    8'(ex_ctrl),    8'h00);
    checkOutput({tag, " mem_ctrl"},   8'(mem_ctrl),   8'h00);
    checkOutput({tag, " wb_ctrl"},    8'(wb_ctrl),    8'h00);
    checkOutput({tag, " ex_valid"},   8'(ex_valid),   8'h00);
    checkOutput({tag, " mem_valid"},  8'(mem_valid),  8'h00);
    checkOutput({tag, " wb_valid"},   8'(wb_valid),   8'h00);
    checkOutput({tag, " fetch_hold"}, 8'(fetch_hold), 8'h00);
    checkOutput({tag, " halted"},     8'(halted),     8'h00);
  endtask

  initial begin
    logic [2:0] prevMem, prevWb, prev2Wb;
    logic       prevValid, prev2Valid;

    // v, op, stall, flush | ex_valid, ex_ctrl, mem_ctrl, wb_ctrl
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 5'b00110, 3'b000, 3'b001};
    vecs[1]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 5'b00110, 3'b000, 3'b001};
    vecs[2]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 5'b00110, 3'b000, 3'b001};
    vecs[3]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 5'b00010, 3'b000, 3'b001};
    vecs[4]  = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 5'b00111, 3'b000, 3'b001};
    vecs[5]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 5'b00111, 3'b000, 3'b001};
    vecs[6]  = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 5'b00111, 3'b000, 3'b001};
    vecs[7]  = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 5'b00010, 3'b000, 3'b001};
    vecs[8]  = '{1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 5'b00011, 3'b101, 3'b011};
    vecs[9]  = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 5'b00001, 3'b110, 3'b000};
    vecs[10] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 5'b00011, 3'b000, 3'b001};
    vecs[11] = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 5'b00011, 3'b000, 3'b001};
    vecs[12] = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 5'b01000, 3'b000, 3'b000};
    vecs[13] = '{1'b1, 4'hD, 1'b0, 1'b0, 1'b1, 5'b10000, 3'b000, 3'b000};
    vecs[14] = '{1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 5'b00010, 3'b000, 3'b101};
    vecs[15] = '{1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 3'b000};
    vecs[16] = '{1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b000, 3'b000};
    vecs[17] = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 5'b00000, 3'b000, 3'b000};
    vecs[18] = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 3'b000};
    vecs[19] = '{1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 3'b000};
    vecs[20] = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b000, 3'b000};
    vecs[21] = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 5'b00111, 3'b000, 3'b001};

    id_valid5 = 1'b0; id_opcode5 = 5'h00; stall5 = 1'b0; flush5 = 1'b0;

    // Reset with live inputs: everything must stay zero.
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
    checkAllZero("reset");
    checkOutput("reset dut5 ex_valid", 8'(ex_valid5), 8'h00);
    rst_n = 1'b1;

    // Table: ID/EX checked against the current vector, EX/MEM and MEM/WB
    // against the vectors one and two cycles earlier.
    prevMem = '0; prevWb = '0; prev2Wb = '0; prevValid = 1'b0; prev2Valid = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].v, vecs[i].op, vecs[i].st, vecs[i].fl);
      checkOutput($sformatf("vec%0d ex_valid", i),   8'(ex_valid),   8'(vecs[i].ev));
      checkOutput($sformatf("vec%0d ex_ctrl", i),    8'(ex_ctrl),    8'(vecs[i].ex));
      checkOutput($sformatf("vec%0d mem_ctrl", i),   8'(mem_ctrl),   8'(prevMem));
      checkOutput($sformatf("vec%0d mem_valid", i),  8'(mem_valid),  8'(prevValid));
      checkOutput($sformatf("vec%0d wb_ctrl", i),    8'(wb_ctrl),    8'(prev2Wb));
      checkOutput($sformatf("vec%0d wb_valid", i),   8'(wb_valid),   8'(prev2Valid));
      checkOutput($sformatf("vec%0d fetch_hold", i), 8'(fetch_hold), 8'h00);
      prev2Wb    = prevWb;
      prev2Valid = prevValid;
      prevMem    = vecs[i].mem;
      prevWb     = vecs[i].wb;
      prevValid  = vecs[i].ev;
    end

    // Load travelling down the pipe.
    applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
    checkOutput("ld ex_ctrl", 8'(ex_ctrl), 8'h03);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("ld mem_ctrl", 8'(mem_ctrl), 8'h05);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("ld wb_ctrl", 8'(wb_ctrl), 8'h03);
    checkOutput("ld wb_valid", 8'(wb_valid), 8'h01);

    // Stall then release.
    applyStimulus(1'b1, 4'h0, 1'b1, 1'b0);
    checkOutput("stall ex_valid", 8'(ex_valid), 8'h00);
    checkOutput("stall ex_ctrl", 8'(ex_ctrl), 8'h00);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
    checkOutput("release ex_ctrl", 8'(ex_ctrl), 8'h06);

    // Stall+flush store: nothing reaches MEM.
    applyStimulus(1'b1, 4'h9, 1'b1, 1'b1);
    checkOutput("stflush ex_valid", 8'(ex_valid), 8'h00);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      checkOutput($sformatf("stflush mem_ctrl c%0d", k),  8'(mem_ctrl),  8'h00);
      checkOutput($sformatf("stflush mem_valid c%0d", k), 8'(mem_valid), 8'h00);
    end

    // Wide-opcode instance: flag mask boundary and out-of-range opcode.
    id_valid5 = 1'b1; id_opcode5 = 5'h03;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("w5 op03 ex_ctrl", 8'(ex_ctrl5), 8'h02);
    id_opcode5 = 5'h13;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("w5 op13 ex_ctrl", 8'(ex_ctrl5), 8'h00);
    checkOutput("w5 op13 ex_valid", 8'(ex_valid5), 8'h01);
    id_opcode5 = 5'h1F;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("w5 op1F fetch_hold", 8'(fetch_hold5), 8'h00);
    id_opcode5 = 5'h0F;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("w5 hlt fetch_hold", 8'(fetch_hold5), 8'h01);
    checkOutput("w5 hlt halted", 8'(halted5), 8'h00);
    id_opcode5 = 5'h01;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("w5 drain1 halted", 8'(halted5), 8'h01);
    checkOutput("w5 drain1 ex_valid", 8'(ex_valid5), 8'h00);
    id_valid5 = 1'b0;

    // HLT drain with DRAIN_CYCLES=3.
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    checkOutput("hlt fetch_hold", 8'(fetch_hold), 8'h01);
    checkOutput("hlt halted e0", 8'(halted), 8'h00);
    checkOutput("hlt ex_ctrl", 8'(ex_ctrl), 8'h02);
    checkOutput("hlt ex_valid", 8'(ex_valid), 8'h01);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("hlt halted e1", 8'(halted), 8'h00);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    checkOutput("hlt halted e2", 8'(halted), 8'h00);
    checkOutput("hlt drain ignored", 8'(ex_valid), 8'h00);
    applyStimulus(1'b0, 4'h1, 1'b0, 1'b0);
    checkOutput("hlt halted e3", 8'(halted), 8'h01);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'(k % 2), 4'h1, 1'b0, 1'b0);
      checkOutput($sformatf("halted stays c%0d", k), 8'(halted), 8'h01);
      checkOutput($sformatf("halted ex_valid c%0d", k), 8'(ex_valid), 8'h00);
      checkOutput($sformatf("halted fetch_hold c%0d", k), 8'(fetch_hold), 8'h01);
    end

    // Reset out of HALTED.
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    checkAllZero("rst halted");
    checkOutput("rst halted dut5", 8'(halted5), 8'h00);
    rst_n = 1'b1;

    // Reset in the middle of DRAIN, then first accept right after.
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("middrain fetch_hold", 8'(fetch_hold), 8'h01);
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    checkAllZero("rst drain");
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    checkOutput("post-rst ex_ctrl", 8'(ex_ctrl), 8'h06);
    checkOutput("post-rst ex_valid", 8'(ex_valid), 8'h01);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      checkOutput($sformatf("post-rst halted c%0d", k), 8'(halted), 8'h00);
      checkOutput($sformatf("post-rst fetch_hold c%0d", k), 8'(fetch_hold), 8'h00);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
